// File: rtl/yapp_tx_engine_if.sv
// Command and YAPP byte-stream signals between the packet engine and its environment.
// master = the engine, slave = the command source / router side.
interface yapp_tx_engine_if #(
   parameter int CNT_WIDTH = 16
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [1:0]           cmd_addr;
   logic [5:0]           cmd_len;
   logic [7:0]           cmd_seed;
   logic                 cmd_bad_parity;
   logic [7:0]           in_data;
   logic                 in_data_vld;
   logic                 in_suspend;
   logic                 pkt_done;
   logic [CNT_WIDTH-1:0] pkt_count;

   modport master (
      input  cmd_valid, cmd_addr, cmd_len, cmd_seed, cmd_bad_parity, in_suspend,
      output cmd_ready, in_data, in_data_vld, pkt_done, pkt_count
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_len, cmd_seed, cmd_bad_parity, in_suspend,
      input  cmd_ready, in_data, in_data_vld, pkt_done, pkt_count
   );
endinterface

// File: rtl/yapp_tx_engine.sv
// YAPP packet transmitter: serializes header, incrementing payload and parity byte
// for one accepted command at a time, holding its output while the router suspends.
module yapp_tx_engine #(
   parameter int GAP_CYCLES = 1,
   parameter int CNT_WIDTH  = 16
) (
   input logic              clock,
   input logic              reset,
   yapp_tx_engine_if.master bus
);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_PARITY, S_GAP} state_t;

   state_t               state_q, state_d;
   logic [1:0]           addr_q, addr_d;
   logic [5:0]           len_q, len_d;
   logic [7:0]           seed_q, seed_d;
   logic                 bad_q, bad_d;
   logic [5:0]           k_q, k_d;
   logic [7:0]           parity_q, parity_d;
   logic [7:0]           data_q, data_d;
   logic                 vld_q, vld_d;
   logic                 done_q, done_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [GW-1:0]        gap_q, gap_d;

   logic       xfer;
   logic [7:0] parity_out;
   logic [7:0] next_byte;

   assign xfer       = vld_q & ~bus.in_suspend;
   assign parity_out = bad_q ? ~parity_q : parity_q;
   assign next_byte  = seed_q + {2'b00, k_q} + 8'd1;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      len_d    = len_q;
      seed_d   = seed_q;
      bad_d    = bad_q;
      k_d      = k_q;
      parity_d = parity_q;
      data_d   = data_q;
      vld_d    = vld_q;
      done_d   = 1'b0;
      count_d  = count_q;
      gap_d    = gap_q;
      unique case (state_q)
         S_IDLE: begin
            vld_d  = 1'b0;
            data_d = '0;
            if (bus.cmd_valid) begin
               addr_d   = bus.cmd_addr;
               len_d    = bus.cmd_len;
               seed_d   = bus.cmd_seed;
               bad_d    = bus.cmd_bad_parity;
               data_d   = {bus.cmd_len, bus.cmd_addr};
               parity_d = {bus.cmd_len, bus.cmd_addr};
               vld_d    = 1'b1;
               k_d      = '0;
               state_d  = S_HEADER;
            end
         end
         // parity_q always includes the byte currently on in_data
         S_HEADER: begin
            if (xfer) begin
               if (len_q == 6'd0) begin
                  data_d  = parity_out;
                  state_d = S_PARITY;
               end else begin
                  data_d   = seed_q;
                  parity_d = parity_q ^ seed_q;
                  k_d      = '0;
                  state_d  = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (xfer) begin
               if (k_q == len_q - 6'd1) begin
                  data_d  = parity_out;
                  state_d = S_PARITY;
               end else begin
                  data_d   = next_byte;
                  parity_d = parity_q ^ next_byte;
                  k_d      = k_q + 6'd1;
               end
            end
         end
         S_PARITY: begin
            if (xfer) begin
               done_d  = 1'b1;
               count_d = count_q + CNT_WIDTH'(1);
               vld_d   = 1'b0;
               data_d  = '0;
               gap_d   = '0;
               state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            end
         end
         S_GAP: begin
            vld_d  = 1'b0;
            data_d = '0;
            if (gap_q == GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         len_q    <= '0;
         seed_q   <= '0;
         bad_q    <= 1'b0;
         k_q      <= '0;
         parity_q <= '0;
         data_q   <= '0;
         vld_q    <= 1'b0;
         done_q   <= 1'b0;
         count_q  <= '0;
         gap_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         seed_q   <= seed_d;
         bad_q    <= bad_d;
         k_q      <= k_d;
         parity_q <= parity_d;
         data_q   <= data_d;
         vld_q    <= vld_d;
         done_q   <= done_d;
         count_q  <= count_d;
         gap_q    <= gap_d;
      end
   end

   assign bus.cmd_ready   = (state_q == S_IDLE);
   assign bus.in_data     = data_q;
   assign bus.in_data_vld = vld_q;
   assign bus.pkt_done    = done_q;
   assign bus.pkt_count   = count_q;
endmodule

// File: tb/tb_yapp_tx_engine.sv
// Bench for yapp_tx_engine: scenario tasks compare the transferred byte stream against
// a packet model built from the YAPP framing rules.
module tb_yapp_tx_engine;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic susp_man = 1'b0;
   logic susp_rnd = 1'b0;
   bit   rand_susp = 1'b0;

   yapp_tx_engine_if #(.CNT_WIDTH(16)) bus();

   yapp_tx_engine #(.GAP_CYCLES(1), .CNT_WIDTH(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.in_suspend = susp_man | susp_rnd;

   always #5 clock = ~clock;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  cap_q[$];
   logic [7:0]  exp_q[$];
   int          gaps[$];
   int          done_cnt = 0;
   int          vld_cycles = 0;
   int          cur_low = 0;
   int          shown_cnt[256];
   logic [15:0] mdl_cnt = '0;

   // Observation of the byte stream, sampled mid-cycle
   always @(negedge clock) begin
      if (!reset) begin
         if (bus.pkt_done) done_cnt++;
         if (bus.in_data_vld) begin
            vld_cycles++;
            shown_cnt[bus.in_data]++;
            if (cur_low > 0) gaps.push_back(cur_low);
            cur_low = 0;
            if (!bus.in_suspend) cap_q.push_back(bus.in_data);
         end else begin
            cur_low++;
         end
      end
   end

   always @(posedge clock) begin
      #1;
      susp_rnd = rand_susp ? ($urandom_range(0, 3) == 0) : 1'b0;
   end

   function automatic void build_exp(input logic [1:0] a, input logic [5:0] l,
                                     input logic [7:0] s, input bit bad);
      logic [7:0] p;
      logic [7:0] b;
      p = {l, a};
      exp_q.push_back(p);
      for (int k = 0; k < int'(l); k++) begin
         b = 8'((int'(s) + k) % 256);
         exp_q.push_back(b);
         p = p ^ b;
      end
      exp_q.push_back(bad ? ~p : p);
   endfunction

   // Drives one command; returns at the cycle after acceptance (posedge+1 phase)
   task automatic send_cmd(input logic [1:0] a, input logic [5:0] l, input logic [7:0] s,
                           input bit bad, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (bus.cmd_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clock); #1;
      end
      if (ok) begin
         bus.cmd_addr       = a;
         bus.cmd_len        = l;
         bus.cmd_seed       = s;
         bus.cmd_bad_parity = bad;
         bus.cmd_valid      = 1'b1;
         @(posedge clock); #1;
         bus.cmd_valid      = 1'b0;
         bus.cmd_addr       = 2'($urandom);
         bus.cmd_len        = 6'($urandom);
         bus.cmd_seed       = 8'($urandom);
         bus.cmd_bad_parity = 1'($urandom);
      end
   endtask

   task automatic wait_done(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(posedge clock); #1;
         if (done_cnt >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      mdl_cnt = '0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (bus.in_data_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%0b want=0", bus.in_data_vld); end
      checks++; if (bus.in_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%02h want=00", bus.in_data); end
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b want=1", bus.cmd_ready); end
      checks++; if (bus.pkt_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", bus.pkt_count); end
      checks++; if (bus.pkt_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b want=0", bus.pkt_done); end
   endtask

   task automatic test_basic();
      bit ok;
      int base, d0, v0;
      exp_q.delete();
      build_exp(2'd2, 6'd3, 8'h10, 1'b0);
      base = cap_q.size(); d0 = done_cnt; v0 = vld_cycles;
      send_cmd(2'd2, 6'd3, 8'h10, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_accept got=timeout want=accepted"); end
      checks++; if (bus.in_data_vld !== 1'b1 || bus.in_data !== exp_q[0]) begin
         errors++; $display("FAIL basic_header_latency got=vld%0b/%02h want=vld1/%02h", bus.in_data_vld, bus.in_data, exp_q[0]);
      end
      wait_done(d0 + 1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_done got=timeout want=pkt_done"); end
      repeat (3) @(posedge clock); #1;
      checks++; if (cap_q.size() - base !== exp_q.size()) begin
         errors++; $display("FAIL basic_len got=%0d want=%0d", cap_q.size() - base, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (cap_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte%0d got=%02h want=%02h", i, cap_q[base + i], exp_q[i]); end
         end
      end
      checks++; if (vld_cycles - v0 !== 5) begin errors++; $display("FAIL basic_vld_cycles got=%0d want=5", vld_cycles - v0); end
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_pulses got=%0d want=1", done_cnt - d0); end
      mdl_cnt++;
      checks++; if (bus.pkt_count !== mdl_cnt) begin errors++; $display("FAIL basic_count got=%0d want=%0d", bus.pkt_count, mdl_cnt); end
   endtask

   task automatic test_suspend();
      bit ok, seen;
      int base, d0, v0, s0;
      exp_q.delete();
      build_exp(2'd2, 6'd3, 8'h10, 1'b0);
      base = cap_q.size(); d0 = done_cnt; v0 = vld_cycles; s0 = shown_cnt[8'h11];
      send_cmd(2'd2, 6'd3, 8'h10, 1'b0, ok);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus.in_data_vld && bus.in_data == 8'h11) begin
            seen = 1'b1;
            break;
         end
         @(posedge clock); #1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL susp_reach got=timeout want=byte11"); end
      susp_man = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      susp_man = 1'b0;
      wait_done(d0 + 1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL susp_done got=timeout want=pkt_done"); end
      repeat (3) @(posedge clock); #1;
      checks++; if (cap_q.size() - base !== exp_q.size()) begin
         errors++; $display("FAIL susp_len got=%0d want=%0d", cap_q.size() - base, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (cap_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL susp_byte%0d got=%02h want=%02h", i, cap_q[base + i], exp_q[i]); end
         end
      end
      checks++; if (shown_cnt[8'h11] - s0 !== 4) begin errors++; $display("FAIL susp_hold got=%0d want=4", shown_cnt[8'h11] - s0); end
      checks++; if (vld_cycles - v0 !== 8) begin errors++; $display("FAIL susp_vld_cycles got=%0d want=8", vld_cycles - v0); end
      mdl_cnt++;
      checks++; if (bus.pkt_count !== mdl_cnt) begin errors++; $display("FAIL susp_count got=%0d want=%0d", bus.pkt_count, mdl_cnt); end
   endtask

   task automatic test_zero_len();
      bit ok;
      int base, d0;
      logic [7:0] want_par;
      for (int b = 0; b < 2; b++) begin
         exp_q.delete();
         build_exp(2'd1, 6'd0, 8'($urandom), b[0]);
         want_par = b[0] ? 8'hFE : 8'h01;
         base = cap_q.size(); d0 = done_cnt;
         send_cmd(2'd1, 6'd0, 8'($urandom), b[0], ok);
         wait_done(d0 + 1, ok);
         checks++; if (!ok) begin errors++; $display("FAIL zlen_done bad=%0d got=timeout want=pkt_done", b); end
         checks++; if (cap_q.size() - base !== 2) begin
            errors++; $display("FAIL zlen_len bad=%0d got=%0d want=2", b, cap_q.size() - base);
         end else begin
            checks++; if (cap_q[base] !== exp_q[0]) begin errors++; $display("FAIL zlen_header bad=%0d got=%02h want=%02h", b, cap_q[base], exp_q[0]); end
            checks++; if (cap_q[base + 1] !== want_par) begin errors++; $display("FAIL zlen_parity bad=%0d got=%02h want=%02h", b, cap_q[base + 1], want_par); end
         end
         mdl_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      bit ok1, ok2, ok;
      int base, d0;
      logic [1:0] a2;
      logic [5:0] l2;
      logic [7:0] s2;
      a2 = 2'($urandom); l2 = 6'($urandom_range(0, 8)); s2 = 8'($urandom);
      exp_q.delete();
      build_exp(2'd3, 6'd63, 8'hF0, 1'b0);
      build_exp(a2, l2, s2, 1'b1);
      base = cap_q.size(); d0 = done_cnt;
      send_cmd(2'd3, 6'd63, 8'hF0, 1'b0, ok1);
      send_cmd(a2, l2, s2, 1'b1, ok2);
      wait_done(d0 + 2, ok);
      checks++; if (!(ok1 && ok2 && ok)) begin errors++; $display("FAIL b2b_done got=timeout want=two_packets"); end
      checks++; if (cap_q.size() - base !== exp_q.size()) begin
         errors++; $display("FAIL b2b_len got=%0d want=%0d", cap_q.size() - base, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (cap_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d got=%02h want=%02h", i, cap_q[base + i], exp_q[i]); end
         end
         checks++; if (cap_q[base + 63] !== 8'h2E) begin errors++; $display("FAIL b2b_wrap got=%02h want=2e", cap_q[base + 63]); end
      end
      checks++; if (gaps.size() == 0 || gaps[gaps.size() - 1] !== 2) begin
         errors++; $display("FAIL b2b_gap got=%0d want=2", (gaps.size() == 0) ? -1 : gaps[gaps.size() - 1]);
      end
      mdl_cnt = mdl_cnt + 16'd2;
      checks++; if (bus.pkt_count !== mdl_cnt) begin errors++; $display("FAIL b2b_count got=%0d want=%0d", bus.pkt_count, mdl_cnt); end
   endtask

   task automatic test_mid_reset();
      bit ok, seen;
      int base, d0;
      apply_reset();
      d0 = done_cnt;
      send_cmd(2'd3, 6'd5, 8'h40, 1'b0, ok);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus.in_data_vld && bus.in_data == 8'h42) begin
            seen = 1'b1;
            break;
         end
         @(posedge clock); #1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL mrst_reach got=timeout want=byte42"); end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      checks++; if (bus.in_data_vld !== 1'b0) begin errors++; $display("FAIL mrst_vld got=%0b want=0", bus.in_data_vld); end
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready got=%0b want=1", bus.cmd_ready); end
      checks++; if (bus.pkt_count !== mdl_cnt) begin errors++; $display("FAIL mrst_count got=%0d want=%0d", bus.pkt_count, mdl_cnt); end
      repeat (4) @(posedge clock); #1;
      checks++; if (done_cnt !== d0) begin errors++; $display("FAIL mrst_no_done got=%0d want=%0d", done_cnt - d0, 0); end
      exp_q.delete();
      build_exp(2'd0, 6'd4, 8'hA5, 1'b0);
      base = cap_q.size(); d0 = done_cnt;
      send_cmd(2'd0, 6'd4, 8'hA5, 1'b0, ok);
      wait_done(d0 + 1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL mrst_done got=timeout want=pkt_done"); end
      checks++; if (cap_q.size() - base !== exp_q.size()) begin
         errors++; $display("FAIL mrst_len got=%0d want=%0d", cap_q.size() - base, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (cap_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL mrst_byte%0d got=%02h want=%02h", i, cap_q[base + i], exp_q[i]); end
         end
      end
      mdl_cnt++;
      checks++; if (bus.pkt_count !== mdl_cnt) begin errors++; $display("FAIL mrst_count_after got=%0d want=%0d", bus.pkt_count, mdl_cnt); end
   endtask

   task automatic test_random();
      bit ok;
      int base, d0;
      logic [1:0] a;
      logic [5:0] l;
      logic [7:0] s;
      bit bad;
      rand_susp = 1'b1;
      for (int n = 0; n < 12; n++) begin
         a = 2'($urandom);
         l = ($urandom_range(0, 5) == 0) ? 6'd63 : 6'($urandom_range(0, 20));
         s = 8'($urandom);
         bad = 1'($urandom);
         exp_q.delete();
         build_exp(a, l, s, bad);
         base = cap_q.size(); d0 = done_cnt;
         send_cmd(a, l, s, bad, ok);
         wait_done(d0 + 1, ok);
         checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_done got=timeout want=pkt_done", n); end
         checks++; if (cap_q.size() - base !== exp_q.size()) begin
            errors++; $display("FAIL rnd%0d_len got=%0d want=%0d", n, cap_q.size() - base, exp_q.size());
         end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
               checks++; if (cap_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_byte%0d got=%02h want=%02h", n, i, cap_q[base + i], exp_q[i]); end
            end
         end
         mdl_cnt++;
         checks++; if (bus.pkt_count !== mdl_cnt) begin errors++; $display("FAIL rnd%0d_count got=%0d want=%0d", n, bus.pkt_count, mdl_cnt); end
      end
      rand_susp = 1'b0;
      repeat (2) @(posedge clock);
      #2;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) shown_cnt[i] = 0;
      bus.cmd_valid      = 1'b0;
      bus.cmd_addr       = '0;
      bus.cmd_len        = '0;
      bus.cmd_seed       = '0;
      bus.cmd_bad_parity = 1'b0;
      test_reset();
      test_basic();
      test_suspend();
      test_zero_len();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
